// File: rtl/pc_sequencer.sv
// Program-counter sequencer: fetch / decode / execute FSM with jump and branch PC selection.
// Optional fetch watchdog enabled by defining SEQ_TIMEOUT_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_data,
  input  logic        instr_valid,
  input  logic        stop,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        zero,
  output logic        instr_req,
  output logic [31:0] instr_addr,
  output logic [5:0]  OpCode,
  output logic [31:0] instr_q,
  output logic        op_valid,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [31:0] pc_r;
  logic [31:0] pc4_s;
  logic [31:0] br_off_s;
  logic [31:0] next_pc_s;
  logic [31:0] instr_q_r;
  logic        instr_req_r;
  logic        op_valid_r;
  logic        timeout_s;

  assign pc4_s    = pc_r + 32'd4;
  assign br_off_s = {{14{instr_q_r[15]}}, instr_q_r[15:0], 2'b00};

  // Next-PC select: jump outranks branch; all sums wrap modulo 2^32.
  always_comb begin
    next_pc_s = pc4_s;
    if (Jump) begin
      next_pc_s = {pc4_s[31:28], instr_q_r[25:0], 2'b00};
    end else if (Branch && zero) begin
      next_pc_s = pc4_s + br_off_s;
    end else begin
      next_pc_s = pc4_s;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [WD_W-1:0] wd_cnt_r;
  logic            fetch_err_r;

  assign timeout_s = (state_r == FETCH) && !instr_valid &&
                     (wd_cnt_r == WD_W'(TIMEOUT_CYC - 1));
  assign fetch_err = fetch_err_r;

  // Watchdog: counts stalled FETCH cycles, clears whenever FETCH is left.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_r    <= '0;
      fetch_err_r <= 1'b0;
    end else begin
      if ((state_r == FETCH) && !instr_valid && !timeout_s) begin
        wd_cnt_r <= wd_cnt_r + WD_W'(1);
      end else begin
        wd_cnt_r <= '0;
      end
      if (timeout_s) begin
        fetch_err_r <= 1'b1;
      end else begin
        fetch_err_r <= fetch_err_r;
      end
    end
  end
`else
  assign timeout_s = 1'b0;
  // Fetch waits forever without the watchdog; the limit only matters when it is built in.
  assign fetch_err = 1'b0 & (TIMEOUT_CYC > 0);
`endif

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE:   next_state_s = FETCH;
      FETCH: begin
        if (instr_valid) begin
          next_state_s = DECODE;
        end else if (timeout_s) begin
          next_state_s = HALT;
        end else begin
          next_state_s = FETCH;
        end
      end
      DECODE: next_state_s = EXEC;
      EXEC:   next_state_s = stop ? HALT : FETCH;
      HALT:   next_state_s = stop ? HALT : FETCH;
      default: next_state_s = IDLE;
    endcase
  end

  // State, PC, instruction latch and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      pc_r        <= RESET_PC;
      instr_q_r   <= 32'h0000_0000;
      instr_req_r <= 1'b0;
      op_valid_r  <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      instr_req_r <= (next_state_s == FETCH);
      op_valid_r  <= (next_state_s == DECODE) || (next_state_s == EXEC);
      if (state_r == EXEC) begin
        pc_r <= next_pc_s;
      end else begin
        pc_r <= pc_r;
      end
      if ((state_r == FETCH) && instr_valid) begin
        instr_q_r <= instr_data;
      end else begin
        instr_q_r <= instr_q_r;
      end
    end
  end

  assign instr_req  = instr_req_r;
  assign op_valid   = op_valid_r;
  assign instr_addr = pc_r;
  assign instr_q    = instr_q_r;
  assign OpCode     = instr_q_r[31:26];

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized instruction stream
// checked against an instruction-level reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr_data = 32'h0;
  logic        instr_valid = 1'b0;
  logic        stop = 1'b0;
  logic        Jump = 1'b0;
  logic        Branch = 1'b0;
  logic        zero = 1'b0;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic [5:0]  OpCode;
  logic [31:0] instr_q;
  logic        op_valid;
  logic        fetch_err;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [31:0] exp_pc;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .instr_data(instr_data), .instr_valid(instr_valid),
    .stop(stop), .Jump(Jump), .Branch(Branch), .zero(zero),
    .instr_req(instr_req), .instr_addr(instr_addr), .OpCode(OpCode),
    .instr_q(instr_q), .op_valid(op_valid), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instruction-level model of the next PC.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] word,
                                             input logic j, input logic b, input logic z);
    logic [31:0]        p4;
    logic signed [15:0] imm;
    int                 off;
    p4  = pc + 32'd4;
    imm = word[15:0];
    off = imm;
    if (j) return (p4 & 32'hF000_0000) | ((word & 32'h03FF_FFFF) << 2);
    if (b && z) return p4 + 32'(off * 4);
    return p4;
  endfunction

  // Runs one instruction starting with the DUT in FETCH; ends with the DUT back in FETCH.
  task automatic run_instr(input logic [31:0] word, input int stall, input logic j,
                           input logic b, input logic z, input logic s, input int halt_cyc);
    int c0;
    c0 = cyc;
    for (int i = 0; i < stall; i++) begin
      instr_valid = 1'b0; instr_data = $urandom; stop = 1'($urandom_range(0, 1));
      Jump = 1'($urandom_range(0, 1)); Branch = 1'($urandom_range(0, 1));
      tick();
      chk("stall_req", {31'd0, instr_req}, 32'd1);
      chk("stall_addr", instr_addr, exp_pc);
    end
    instr_valid = 1'b1; instr_data = word; stop = 1'($urandom_range(0, 1));
    tick();
    chk("dec_opv", {31'd0, op_valid}, 32'd1);
    chk("dec_op", {26'd0, OpCode}, {26'd0, word[31:26]});
    chk("dec_q", instr_q, word);
    chk("dec_req", {31'd0, instr_req}, 32'd0);
    instr_valid = 1'($urandom_range(0, 1)); instr_data = $urandom; stop = 1'($urandom_range(0, 1));
    tick();
    chk("exec_opv", {31'd0, op_valid}, 32'd1);
    chk("exec_addr", instr_addr, exp_pc);
    chk("exec_q", instr_q, word);
    Jump = j; Branch = b; zero = z; stop = s; instr_valid = 1'($urandom_range(0, 1));
    tick();
    exp_pc = model_next(exp_pc, word, j, b, z);
    chk("next_pc", instr_addr, exp_pc);
    if (s) begin
      chk("halt_req", {31'd0, instr_req}, 32'd0);
      chk("halt_opv", {31'd0, op_valid}, 32'd0);
      for (int i = 0; i < halt_cyc; i++) begin
        stop = 1'b1; instr_valid = 1'($urandom_range(0, 1));
        tick();
        chk("hold_req", {31'd0, instr_req}, 32'd0);
        chk("hold_pc", instr_addr, exp_pc);
      end
      stop = 1'b0;
      tick();
    end else begin
      chk("cadence", 32'(cyc - c0), 32'(3 + stall));
    end
    chk("fetch_req", {31'd0, instr_req}, 32'd1);
    chk("fetch_opv", {31'd0, op_valid}, 32'd0);
    chk("fetch_addr", instr_addr, exp_pc);
    Jump = 1'b0; Branch = 1'b0; zero = 1'b0; stop = 1'b0; instr_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    exp_pc = 32'h0000_0000;
    #1;
    chk("rst_req", {31'd0, instr_req}, 32'd0);
    chk("rst_pc", instr_addr, 32'h0);
    chk("rst_q", instr_q, 32'h0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("first_fetch", {31'd0, instr_req}, 32'd1);
    chk("first_addr", instr_addr, 32'h0);

    // Sequential fetch 0,4,8,C with opcode 08.
    for (int i = 0; i < 4; i++) begin
      w = $urandom; w[31:26] = 6'h08;
      run_instr(w, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    end
    chk("seq_pc", instr_addr, 32'h0000_0010);

    // Jump (with branch also asserted) from 0x10.
    run_instr(32'h0800_0040, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    chk("jump_tgt", instr_addr, 32'h0000_0100);

    // Backward branch from 0x20, then not-taken branch from 0x20.
    run_instr(32'h0800_0008, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    run_instr(32'h1000_FFFE, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    chk("br_taken", instr_addr, 32'h0000_001C);
    run_instr(32'h0000_0000, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    run_instr(32'h1000_FFFE, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    chk("br_not", instr_addr, 32'h0000_0024);

    // Wrap: reach 0xFFFF_FFFC, then stop -> pc 0 in HALT.
    run_instr(32'h0800_0000, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    run_instr(32'h1000_FFFE, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    chk("wrap_pre", instr_addr, 32'hFFFF_FFFC);
    run_instr(32'h2000_1234, 0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    chk("wrap_pc", instr_addr, 32'h0000_0000);

    // Randomized instruction stream.
    for (int i = 0; i < 40; i++) begin
      run_instr($urandom, $urandom_range(0, 2), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

`ifdef SEQ_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      chk("wd_pre_err", {31'd0, fetch_err}, 32'd0);
      chk("wd_pre_req", {31'd0, instr_req}, 32'd1);
      instr_valid = 1'b0; stop = 1'b0;
      tick();
    end
    chk("wd_err", {31'd0, fetch_err}, 32'd1);
    chk("wd_halt_req", {31'd0, instr_req}, 32'd0);
    chk("wd_halt_pc", instr_addr, exp_pc);
    tick();
    chk("wd_refetch", {31'd0, instr_req}, 32'd1);
    chk("wd_sticky", {31'd0, fetch_err}, 32'd1);
`else
    for (int i = 0; i < 10; i++) begin
      instr_valid = 1'b0; stop = 1'b1;
      tick();
      chk("wait_req", {31'd0, instr_req}, 32'd1);
      chk("wait_err", {31'd0, fetch_err}, 32'd0);
    end
    stop = 1'b0;
`endif
    run_instr($urandom, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);

    // Reset during FETCH with a valid response pending.
    w = instr_q;
    instr_valid = 1'b1; instr_data = ~w;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req", {31'd0, instr_req}, 32'd0);
    chk("mid_rst_opv", {31'd0, op_valid}, 32'd0);
    chk("mid_rst_pc", instr_addr, 32'h0);
    chk("mid_rst_q", instr_q, 32'h0);
    chk("mid_rst_op", {26'd0, OpCode}, 32'd0);
    chk("mid_rst_err", {31'd0, fetch_err}, 32'd0);
    tick();
    chk("mid_rst_q2", instr_q, 32'h0);
    instr_valid = 1'b0;
    rst = 1'b0;
    exp_pc = 32'h0;
    tick();
    chk("post_rst_req", {31'd0, instr_req}, 32'd1);
    run_instr($urandom, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    chk("post_rst_pc", instr_addr, 32'h0000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
